// File: rtl/framebuffer_writer_if.sv
// Command channel from the game logic into the framebuffer writer:
// valid/ready handshake plus the pixel/clear command fields.
interface framebuffer_writer_if #(
    parameter int COLOR_W = 4
) ();
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_clear;
    logic [9:0]         cmd_x;
    logic [8:0]         cmd_y;
    logic [COLOR_W-1:0] cmd_color;

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/framebuffer_writer.sv
// Write-side front end of the palette-index framebuffer. Accepts single-pixel
// writes and full-screen clears, converts (x, y) to a linear address and
// issues at most one RAM write per cycle. Off-screen writes are dropped and
// counted in a saturating counter that only reset clears.
module framebuffer_writer #(
    parameter int H_RES   = 800,
    parameter int V_RES   = 480,
    parameter int COLOR_W = 4,
    parameter int ADDR_W  = 19
) (
    input  logic               clock,
    input  logic               reset,
    framebuffer_writer_if.slave cmd,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [COLOR_W-1:0] ram_wdata,
    output logic               busy,
    output logic [15:0]        drop_count
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [31:0]       H_RES_U   = 32'(H_RES);
    localparam logic [31:0]       V_RES_U   = 32'(V_RES);
    localparam logic [ADDR_W-1:0] H_COEF    = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    // Constant-coefficient multiply y*H_RES + x built from shifted copies of y,
    // one per set bit of H_RES (for 800: (y<<9)+(y<<8)+(y<<5)).
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic [8:0] y,
        input logic [9:0] x
    );
        logic [ADDR_W-1:0] acc;
        logic [ADDR_W-1:0] y_ext;
        acc   = {{(ADDR_W-10){1'b0}}, x};
        y_ext = {{(ADDR_W-9){1'b0}}, y};
        for (int i = 0; i < ADDR_W; i++) begin
            if (H_COEF[i]) begin
                acc = acc + (y_ext << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    state_t             state_r;
    logic               cmd_ready_r;
    logic               ram_we_r;
    logic [ADDR_W-1:0]  ram_addr_r;
    logic [COLOR_W-1:0] ram_wdata_r;
    logic [COLOR_W-1:0] fill_r;
    logic               busy_r;
    logic [15:0]        drop_count_r;

    logic [ADDR_W-1:0]  lin_addr_s;
    logic               in_range_s;
    logic               accept_s;

    // Address and on-screen test for the coordinates currently presented
    always_comb begin
        lin_addr_s = pixel_addr(cmd.cmd_y, cmd.cmd_x);
        in_range_s = ({22'd0, cmd.cmd_x} < H_RES_U) && ({23'd0, cmd.cmd_y} < V_RES_U);
        accept_s   = cmd.cmd_valid && cmd_ready_r;
    end

    // Command FSM: pixel writes in IDLE, linear fill sweep in CLEAR; all outputs registered
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            cmd_ready_r  <= 1'b0;
            ram_we_r     <= 1'b0;
            ram_addr_r   <= '0;
            ram_wdata_r  <= '0;
            fill_r       <= '0;
            busy_r       <= 1'b0;
            drop_count_r <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    if (accept_s && cmd.cmd_clear) begin
                        state_r     <= CLEAR;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        fill_r      <= cmd.cmd_color;
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= '0;
                        ram_wdata_r <= cmd.cmd_color;
                    end else if (accept_s && in_range_s) begin
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= lin_addr_s;
                        ram_wdata_r <= cmd.cmd_color;
                    end else if (accept_s) begin
                        // Off-screen: consume the command, no write, count it
                        ram_we_r <= 1'b0;
                        if (drop_count_r != 16'hFFFF) begin
                            drop_count_r <= drop_count_r + 16'd1;
                        end else begin
                            drop_count_r <= drop_count_r;
                        end
                    end else begin
                        ram_we_r <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (ram_addr_r == LAST_ADDR) begin
                        // Last pixel was written this cycle; hand back to IDLE
                        state_r     <= IDLE;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        ram_we_r    <= 1'b0;
                    end else begin
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= ram_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        ram_wdata_r <= fill_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                    ram_we_r    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = cmd_ready_r;
    assign ram_we        = ram_we_r;
    assign ram_addr      = ram_addr_r;
    assign ram_wdata     = ram_wdata_r;
    assign busy          = busy_r;
    assign drop_count    = drop_count_r;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer. A reduced-height instance (800x8) carries the
// scoreboard tests so clear sweeps stay short; a full 800x480 instance covers
// the far-corner address and back-to-back pipeline timing.
module tb_framebuffer_writer;

    localparam int H     = 800;
    localparam int V     = 8;
    localparam int CW    = 4;
    localparam int AW    = 19;
    localparam int TOTAL = H * V;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    framebuffer_writer_if #(.COLOR_W(CW)) cif ();
    framebuffer_writer_if #(.COLOR_W(CW)) fif ();

    logic          ram_we,   f_ram_we;
    logic [AW-1:0] ram_addr, f_ram_addr;
    logic [CW-1:0] ram_wdata, f_ram_wdata;
    logic          busy,     f_busy;
    logic [15:0]   drop_count, f_drop_count;

    framebuffer_writer #(.H_RES(H), .V_RES(V), .COLOR_W(CW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .cmd(cif.slave),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .busy(busy), .drop_count(drop_count)
    );

    framebuffer_writer dut_full (
        .clock(clock), .reset(reset), .cmd(fif.slave),
        .ram_we(f_ram_we), .ram_addr(f_ram_addr), .ram_wdata(f_ram_wdata),
        .busy(f_busy), .drop_count(f_drop_count)
    );

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          clr_lo      = 1;
    int          clr_hi      = 0;
    int          exp_drops   = 0;
    logic [CW-1:0] model_mem [TOTAL];
    logic [CW-1:0] dut_mem   [TOTAL];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bench cycle counter used to time-stamp expected writes
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitor: every RAM write must match the next expected entry in order and cycle
    always @(negedge clock) begin
        exp_t e;
        chk("busy", busy, (cyc >= clr_lo) && (cyc <= clr_hi));
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missed_write_cycle", sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (ram_we === 1'b1) begin
            chk("addr_in_range", ram_addr < AW'(TOTAL), 1'b1);
            if (ram_addr < AW'(TOTAL)) dut_mem[ram_addr] = ram_wdata;
            if (sb.size() == 0) begin
                chk("spurious_we", ram_we, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", ram_addr, e.addr);
                chk("wr_data", ram_wdata, e.data);
            end
        end
    end

    // Present one command, wait (bounded) for acceptance, record expectations
    task automatic send(input logic clr, input int x, input int y, input int color,
                        output int waited);
        logic [9:0]    xs;
        logic [8:0]    ys;
        logic [CW-1:0] cs;
        xs = x[9:0];
        ys = y[8:0];
        cs = color[CW-1:0];
        waited = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_clear = clr;
        cif.cmd_x     = xs;
        cif.cmd_y     = ys;
        cif.cmd_color = cs;
        @(negedge clock);
        while (cif.cmd_ready !== 1'b1 && waited < 20000) begin
            waited++;
            @(negedge clock);
        end
        if (cif.cmd_ready !== 1'b1) begin
            chk("accept_timeout", cif.cmd_ready, 1'b1);
        end else if (clr) begin
            for (int i = 0; i < TOTAL; i++) begin
                sb.push_back('{addr: i, data: color, cyc: cyc + 1 + i});
                model_mem[i] = cs;
            end
            clr_lo = cyc + 1;
            clr_hi = cyc + TOTAL;
        end else if (x < H && y < V) begin
            sb.push_back('{addr: y * H + x, data: color, cyc: cyc + 1});
            model_mem[y * H + x] = cs;
        end else begin
            exp_drops = (exp_drops == 65535) ? 65535 : exp_drops + 1;
        end
        @(posedge clock);
        #1;
        cif.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        int diffs;
        cif.cmd_valid = 1'b0; cif.cmd_clear = 1'b0; cif.cmd_x = 10'd0;
        cif.cmd_y = 9'd0; cif.cmd_color = 4'd0;
        fif.cmd_valid = 1'b0; fif.cmd_clear = 1'b0; fif.cmd_x = 10'd0;
        fif.cmd_y = 9'd0; fif.cmd_color = 4'd0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", cif.cmd_ready, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drops", drop_count, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("ready_after_rst", cif.cmd_ready, 1'b1);
        chk("full_ready_after_rst", fif.cmd_ready, 1'b1);

        // Full-size instance: far corner and back-to-back timing
        fif.cmd_valid = 1'b1; fif.cmd_x = 10'd799; fif.cmd_y = 9'd479; fif.cmd_color = 4'h3;
        @(posedge clock); #1;
        chk("full_we0", f_ram_we, 1'b1);
        chk("full_addr0", f_ram_addr, 383999);
        chk("full_data0", f_ram_wdata, 4'h3);
        chk("full_ready0", fif.cmd_ready, 1'b1);
        fif.cmd_x = 10'd1; fif.cmd_y = 9'd1; fif.cmd_color = 4'h5;
        @(posedge clock); #1;
        chk("full_addr1", f_ram_addr, 801);
        chk("full_data1", f_ram_wdata, 4'h5);
        chk("full_ready1", fif.cmd_ready, 1'b1);
        fif.cmd_x = 10'd10; fif.cmd_y = 9'd2; fif.cmd_color = 4'hF;
        @(posedge clock); #1;
        chk("full_we2", f_ram_we, 1'b1);
        chk("full_addr2", f_ram_addr, 1610);
        chk("full_data2", f_ram_wdata, 4'hF);
        fif.cmd_x = 10'd1023; fif.cmd_y = 9'd511;
        @(posedge clock); #1;
        chk("full_max_no_we", f_ram_we, 1'b0);
        fif.cmd_x = 10'd800; fif.cmd_y = 9'd479;
        @(posedge clock); #1;
        chk("full_x800_no_we", f_ram_we, 1'b0);
        fif.cmd_x = 10'd799; fif.cmd_y = 9'd480;
        @(posedge clock); #1;
        chk("full_y480_no_we", f_ram_we, 1'b0);
        fif.cmd_valid = 1'b0;
        @(posedge clock); #1;
        chk("full_drops", f_drop_count, 3);
        chk("full_idle_we", f_ram_we, 1'b0);

        // Single write, then back-to-back writes on the scoreboard instance
        send(1'b0, 0, 0, 4'hA, w);
        send(1'b0, 799, V - 1, 4'h3, w);
        send(1'b0, 1, 1, 4'h5, w);
        chk("b2b_ready1", w, 0);
        send(1'b0, 10, 2, 4'hF, w);
        chk("b2b_ready2", w, 0);
        drain();

        // Off-screen drops, then saturation
        send(1'b0, 800, 0, 4'h1, w);
        send(1'b0, 0, V, 4'h1, w);
        send(1'b0, 1023, 511, 4'h1, w);
        drain();
        chk("drops3", drop_count, exp_drops);
        for (int i = 0; i < 65537; i++) send(1'b0, 1023, 511, 4'h2, w);
        drain();
        chk("drops_sat", drop_count, 16'hFFFF);
        chk("drops_model", drop_count, exp_drops);

        // Clear with a write held during the sweep
        send(1'b1, 123, 45, 4'h7, w);
        send(1'b0, 5, 3, 4'h9, w);
        chk("held_wait", w, TOTAL);
        drain();
        chk("drops_kept_by_clear", drop_count, 16'hFFFF);

        // Random stream against the reference image
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
            end
            send(1'b0, $urandom_range(0, 850), $urandom_range(0, V + 2), $urandom_range(0, 15), w);
        end
        drain();
        diffs = 0;
        for (int i = 0; i < TOTAL; i++) if (dut_mem[i] !== model_mem[i]) diffs++;
        chk("image_diffs", diffs, 0);

        // Reset while the sweep is at address 1000
        send(1'b1, 0, 0, 4'h2, w);
        w = 0;
        while (ram_addr !== AW'(1000) && w < 20000) begin
            @(negedge clock);
            w++;
        end
        chk("reached_1000", ram_addr, 1000);
        reset = 1'b1;
        clr_hi = cyc;
        @(posedge clock); #1;
        sb.delete();
        exp_drops = 0;
        chk("midrst_we", ram_we, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_addr", ram_addr, 0);
        chk("midrst_drops", drop_count, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("midrst_ready", cif.cmd_ready, 1'b1);
        send(1'b0, 3, 4, 4'h6, w);
        drain();
        chk("post_rst_drops", drop_count, exp_drops);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/framebuffer_writer.md
Name: framebuffer_writer

Overview:
- Write-side front end of the 800x480, 4-bit palette-index framebuffer that the screen driver scans out.
- Accepts pixel-write and full-screen clear commands from the game logic over a valid/ready handshake.
- Converts coordinates to a linear framebuffer address and issues one RAM write per cycle.
- Rejects off-screen coordinates and counts how many it has rejected.

Parameters:
- H_RES, 800, visible pixels per line.
- V_RES, 480, visible lines per frame.
- COLOR_W, 4, palette index width in bits.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_clear  in  1  1 = clear whole screen, 0 = single pixel write.
- cmd_x  in  10  pixel column.
- cmd_y  in  9  pixel row.
- cmd_color  in  COLOR_W  palette index to write, or fill colour for a clear.
- ram_we  out  1  framebuffer write enable.
- ram_addr  out  ADDR_W  framebuffer write address.
- ram_wdata  out  COLOR_W  framebuffer write data.
- busy  out  1  clear sweep in progress.
- drop_count  out  16  number of rejected off-screen writes; saturates.

Behaviour:
- Interface: clock and reset are named as above; one clock domain; reset is synchronous and active-high.
- Reset values: cmd_ready=0 during reset and 1 on the first cycle after reset deasserts; ram_we=0; ram_addr=0; ram_wdata=0; busy=0; drop_count=0; state=IDLE.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. Command fields are sampled only on acceptance. cmd_ready is a registered output, high only in IDLE.
- States: IDLE, CLEAR.
- IDLE, pixel write (accepted, cmd_clear=0):
  - Address = cmd_y*H_RES + cmd_x. Implement the multiply as shift-adds ((y<<9)+(y<<8)+(y<<5)+x for 800); no DSP multiplier.
  - If cmd_x < H_RES and cmd_y < V_RES: on the next cycle, ram_we=1, ram_addr=address, ram_wdata=cmd_color. Latency is exactly 1 cycle.
  - Otherwise the command is consumed: ram_we=0 and drop_count+1, saturating at 16'hFFFF.
  - Back-to-back writes sustain one write per cycle; cmd_ready stays 1.
- IDLE, clear (accepted, cmd_clear=1):
  - cmd_x and cmd_y are ignored; cmd_color is latched as the fill colour.
  - Next cycle: state=CLEAR, busy=1, cmd_ready=0, ram_we=1, ram_addr=0.
- CLEAR:
  - Each cycle ram_addr increments by 1 with ram_we=1 and ram_wdata=fill colour. The sweep is exactly H_RES*V_RES write cycles (addresses 0..383999).
  - The cycle after address 383999 is written: ram_we=0, busy=0, cmd_ready=1, state=IDLE.
  - A command held on cmd_valid during CLEAR waits and is not lost (valid/ready rule).
- ram_we is never asserted for an address >= H_RES*V_RES.
- ram_addr and ram_wdata hold their last values when ram_we=0; they are don't-care to the consumer.
- Reset asserted mid-clear: the sweep is aborted on that edge, all outputs go to their reset values, and a partially cleared framebuffer is acceptable.
- Boundaries:
  - x=799, y=479 maps to 383999 and is written.
  - x=800 or y=480 is dropped.
  - Max inputs (x=1023, y=511) are dropped with no address overflow side effects.
- drop_count is not cleared by a clear command; it is cleared only by reset.

Test Plan:
- Reset, then a single write (x=0, y=0, color=4'hA) -> one cycle later ram_we=1, ram_addr=0, ram_wdata=A; next cycle ram_we=0.
- Back-to-back writes (799,479,3), (1,1,5), (10,2,F) on consecutive cycles -> ram_addr 383999, 801, 1610 on consecutive cycles; cmd_ready stays 1.
- Writes (800,0), (0,480), (1023,511) -> no ram_we; drop_count=3. Then force 65540 drops -> drop_count=FFFF.
- Clear with color=7 -> busy high for exactly 384000 cycles; ram_we on every one; addresses 0..383999 in order, each with data 7. A write held valid during the sweep is accepted the cycle cmd_ready returns and written one cycle later.
- Assert reset at sweep address 1000 -> next cycle ram_we=0, busy=0, ram_addr=0; after reset deasserts a new write completes normally.
- Random write stream checked against a reference model of the 800x480 array -> final memory image matches; no ram_we with address >= 384000.
